trdb_branch_map_unpacker: RTL
=============================

Name: trdb_branch_map_unpacker

Overview:
- Decoder-side counterpart of the encoder's branch tracking. It accepts one branch-map field (count plus map bits) taken from a received trace packet, then serialises it into a per-branch taken/not-taken stream.
- The decoder's instruction-reconstruction engine consumes this stream, one bit per conditional branch it walks past.
- Sits between the packet parser and the PC reconstruction logic, with a valid/ready handshake on both sides.

Parameters:
- MAP_LEN, 31, maximum branch-map length in bits.
- CNT_W, 5, width of the branch count field; 2**CNT_W must be greater than MAP_LEN.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous discard of all held state (decoder resync)
- map_valid_i  in  1  parser presents a branch map
- map_ready_o  out  1  block accepts the map this cycle
- map_count_i  in  CNT_W  number of valid branches; 0 encodes a full map of MAP_LEN
- map_bits_i  in  MAP_LEN  bit 0 = oldest branch; 0 = taken, 1 = not taken
- br_valid_o  out  1  a branch outcome is presented
- br_ready_i  in  1  reconstruction engine consumes the outcome
- br_taken_o  out  1  outcome of the current branch
- br_last_o  out  1  the current outcome is the final one of the loaded map
- busy_o  out  1  a map is held and not yet fully drained
- overflow_o  out  1  sticky; map_count_i > MAP_LEN was accepted (cleared by flush_i or reset)

Behaviour:
- Reset (rst_ni low, asynchronous): state IDLE; shift register and counter cleared.
  - Output values during reset: br_valid_o=0, br_taken_o=0, br_last_o=0, busy_o=0, overflow_o=0, map_ready_o=1.
- States: IDLE and DRAIN.
- IDLE:
  - map_ready_o=1 and br_valid_o=0.
  - On map_valid_i & map_ready_o, latch map_bits_i into the shift register.
  - Load the remaining counter with (map_count_i==0 ? MAP_LEN : map_count_i).
  - If map_count_i > MAP_LEN, set overflow_o and clamp the counter to MAP_LEN.
  - Then go to DRAIN.
- DRAIN:
  - map_ready_o=0; busy_o=1; br_valid_o=1.
  - br_taken_o = ~shift[0].
  - br_last_o = (remaining==1).
  - On br_valid_o & br_ready_i: shift right by 1 (zero fill) and decrement remaining.
  - If remaining was 1, return to IDLE in the next cycle.
- Latency: the first outcome is visible the cycle after the map handshake. One outcome is delivered per cycle while br_ready_i=1. A 1-cycle bubble (IDLE) occurs between maps.
- br_taken_o and br_last_o are registered-state driven and stay stable while br_valid_o=1 and br_ready_i=0.
- flush_i has priority over all handshakes: next state IDLE, counter 0, overflow_o cleared. No handshake completes in a flush cycle on either side.
- A map load while a map is draining is impossible by construction (map_ready_o=0).
- No wrap-around: the counter never decrements below 0, because the handshake is gated by br_valid_o.

Optional Feature:
- Macro TRDB_BMAP_PREFETCH_EN.
- When defined, a second map slot (prefetch register, count, valid flag) is added:
  - map_ready_o = ~prefetch_valid, in any state.
  - A map accepted during DRAIN is stored in the prefetch slot.
  - When the last outcome of the current map is consumed and the prefetch slot is valid, the prefetch map is promoted in the same cycle. The state stays DRAIN, with no bubble.
  - If the last outcome is consumed while a new map is being accepted and the prefetch slot is empty, the new map loads directly into the active slot.
  - busy_o stays 1 while either slot is valid.
  - flush_i clears both slots.
- When not defined: single slot, behaviour exactly as above.

Test Plan:
- Reset with the map side idle -> br_valid_o=0, busy_o=0, overflow_o=0, map_ready_o=1.
- Load count=3, bits=3'b010, br_ready_i=1 -> outcomes taken, not-taken, taken on three consecutive cycles; br_last_o=1 only on the 3rd; IDLE on the 4th cycle.
- Load count=0, bits all 0 -> 31 taken outcomes, br_last_o on the 31st; hold br_ready_i=0 for 5 cycles mid-stream -> outputs stable, no outcome lost.
- Load count=1 -> first outcome and br_last_o=1 in the same cycle; map_ready_o returns to 1 the cycle after consumption.
- Load count=31, drain 10 outcomes, then assert flush_i -> next cycle br_valid_o=0, busy_o=0; a fresh map with count=2 drains correctly.
- With TRDB_BMAP_PREFETCH_EN: load map A (count=2), load map B (count=2) during A's drain -> 4 consecutive outcomes with no bubble; map_ready_o=0 while B waits.

Source files
------------

// File: rtl/trdb_branch_map_unpacker.sv
// ============================================================================
// Module   : trdb_branch_map_unpacker
// Purpose  : Decoder-side branch-map serialiser. Accepts one branch-map field
//            (count + map bits) from the packet parser and presents it as a
//            per-branch taken/not-taken stream to the PC reconstruction engine.
//            Optional macro TRDB_BMAP_PREFETCH_EN adds a second map slot so
//            back-to-back maps drain without a bubble.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module trdb_branch_map_unpacker #(
  parameter int MAP_LEN = 31,
  parameter int CNT_W   = 5
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               map_valid_i,
  output logic               map_ready_o,
  input  logic [CNT_W-1:0]   map_count_i,
  input  logic [MAP_LEN-1:0] map_bits_i,
  output logic               br_valid_o,
  input  logic               br_ready_i,
  output logic               br_taken_o,
  output logic               br_last_o,
  output logic               busy_o,
  output logic               overflow_o
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAP_LEN);
  localparam logic [CNT_W:0]   LEN_EXT  = (CNT_W+1)'(MAP_LEN);

  state_e             state_q;
  logic [MAP_LEN-1:0] shift_q;
  logic [CNT_W-1:0]   rem_q;
  logic               ovf_q;

  logic               in_over;
  logic [CNT_W-1:0]   in_cnt;
  logic               map_fire;
  logic               br_fire;
  logic               last_q;

  // Count decode: zero means a full map, oversized counts clamp to a full map.
  assign in_over  = {1'b0, map_count_i} > LEN_EXT;
  assign in_cnt   = ((map_count_i == '0) || in_over) ? CNT_FULL : map_count_i;

  // A flush cycle discards whatever is offered on either side.
  assign map_fire = map_valid_i & map_ready_o & ~flush_i;
  assign br_fire  = br_valid_o & br_ready_i & ~flush_i;
  assign last_q   = (rem_q == CNT_ONE);

  // Outcome side is driven purely from held state, so it is stable under stall.
  assign br_valid_o = (state_q == DRAIN);
  assign br_taken_o = br_valid_o & ~shift_q[0];
  assign br_last_o  = br_valid_o & last_q;
  assign overflow_o = ovf_q;

`ifdef TRDB_BMAP_PREFETCH_EN

  logic [MAP_LEN-1:0] pf_bits_q;
  logic [CNT_W-1:0]   pf_cnt_q;
  logic               pf_valid_q;

  assign map_ready_o = ~pf_valid_q;
  assign busy_o      = (state_q == DRAIN) | pf_valid_q;

  // Two-slot FSM: active slot drains, prefetch slot is promoted on the last outcome.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      rem_q      <= '0;
      ovf_q      <= 1'b0;
      pf_bits_q  <= '0;
      pf_cnt_q   <= '0;
      pf_valid_q <= 1'b0;
    end else if (flush_i) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      rem_q      <= '0;
      ovf_q      <= 1'b0;
      pf_bits_q  <= '0;
      pf_cnt_q   <= '0;
      pf_valid_q <= 1'b0;
    end else begin
      if (map_fire && in_over) begin
        ovf_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (map_fire) begin
            shift_q <= map_bits_i;
            rem_q   <= in_cnt;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (br_fire && last_q) begin
            if (pf_valid_q) begin
              // Prefetched map takes over with no bubble.
              shift_q    <= pf_bits_q;
              rem_q      <= pf_cnt_q;
              pf_valid_q <= 1'b0;
            end else if (map_fire) begin
              // Map arriving exactly on the last outcome bypasses the prefetch slot.
              shift_q <= map_bits_i;
              rem_q   <= in_cnt;
            end else begin
              shift_q <= shift_q >> 1;
              rem_q   <= rem_q - CNT_ONE;
              state_q <= IDLE;
            end
          end else begin
            if (br_fire) begin
              shift_q <= shift_q >> 1;
              rem_q   <= rem_q - CNT_ONE;
            end
            if (map_fire) begin
              pf_bits_q  <= map_bits_i;
              pf_cnt_q   <= in_cnt;
              pf_valid_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`else

  assign map_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q == DRAIN);

  // Single-slot FSM: load in IDLE, shift one outcome out per consumed beat in DRAIN.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      shift_q <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (flush_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (map_fire && in_over) begin
        ovf_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (map_fire) begin
            shift_q <= map_bits_i;
            rem_q   <= in_cnt;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (br_fire) begin
            shift_q <= shift_q >> 1;
            rem_q   <= rem_q - CNT_ONE;
            if (last_q) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`endif

endmodule

`default_nettype wire
